// File: rtl/rv_ctrl_pkg.sv
// RV32I control-unit shared definitions: opcodes, ALU/imm/result encodings,
// per-stage control words and stage-to-stage narrowing helpers.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam int ALU_W = 4;
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'd8;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_F3  = 2'b10;

   // Everything EX needs, plus the fields that ride on to MEM/WB.
   typedef struct packed {
      logic             reg_write;
      logic             alu_src;
      logic             mem_write;
      logic [1:0]       result_src;
      logic             branch;
      logic             jump;
      logic             jalr;
      logic [ALU_W-1:0] alu_ctrl;
      logic             illegal;
      logic [2:0]       funct3;
   } ex_ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic [1:0] result_src;
   } mem_ctrl_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } wb_ctrl_t;

   function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t c);
      return '{reg_write: c.reg_write, mem_write: c.mem_write, result_src: c.result_src};
   endfunction

   function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t c);
      return '{reg_write: c.reg_write, result_src: c.result_src};
   endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Handshake bundle between the datapath and the control unit.
interface pipelined_control_unit_if #(parameter int ALU_CTRL_W = 4);
   logic [6:0]            Op;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic                  FlushE;
   logic                  ZeroE;
   logic                  LtE;
   logic                  LtuE;
   logic [2:0]            ImmSrcD;
   logic                  IllegalD;
   logic [ALU_CTRL_W-1:0] ALUControlE;
   logic                  ALUSrcE;
   logic                  JalrE;
   logic                  PCSrcE;
   logic                  IllegalE;
   logic                  MemWriteM;
   logic                  RegWriteM;
   logic [1:0]            ResultSrcM;
   logic                  RegWriteW;
   logic [1:0]            ResultSrcW;

   modport master (
      output Op, funct3, funct7, FlushE, ZeroE, LtE, LtuE,
      input  ImmSrcD, IllegalD, ALUControlE, ALUSrcE, JalrE, PCSrcE, IllegalE,
             MemWriteM, RegWriteM, ResultSrcM, RegWriteW, ResultSrcW
   );

   modport slave (
      input  Op, funct3, funct7, FlushE, ZeroE, LtE, LtuE,
      output ImmSrcD, IllegalD, ALUControlE, ALUSrcE, JalrE, PCSrcE, IllegalE,
             MemWriteM, RegWriteM, ResultSrcM, RegWriteW, ResultSrcW
   );
endinterface

// File: rtl/rv_ctrl_decode.sv
// ID-stage decode: opcode -> control word, funct3/funct7 -> ALU operation.
module rv_ctrl_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [2:0] imm_src,
   output ex_ctrl_t   ctrl
);

   logic [1:0] alu_op;
   logic       unused_f7;

   // only funct7[5] distinguishes SUB/SRA from ADD/SRL
   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   // main decode then ALU decode; unknown opcodes become an illegal bubble
   always_comb begin
      ctrl    = '0;
      imm_src = IMM_I;
      alu_op  = ALUOP_ADD;
      case (op)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            imm_src        = IMM_S;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_R: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_ALU;
            alu_op          = ALUOP_F3;
         end
         OP_IALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            alu_op         = ALUOP_F3;
         end
         OP_BRANCH: begin
            imm_src     = IMM_B;
            ctrl.branch = 1'b1;
            alu_op      = ALUOP_SUB;
         end
         OP_JAL: begin
            imm_src         = IMM_J;
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.jump       = 1'b1;
         end
         OP_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_PC4;
            ctrl.jump       = 1'b1;
            ctrl.jalr       = 1'b1;
         end
         OP_LUI: begin
            imm_src         = IMM_U;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_IMM;
         end
         default: ctrl.illegal = 1'b1;
      endcase

      case (alu_op)
         ALUOP_ADD: ctrl.alu_ctrl = ALU_ADD;
         ALUOP_SUB: ctrl.alu_ctrl = ALU_SUB;
         default: begin
            case (funct3)
               3'b000:  ctrl.alu_ctrl = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  ctrl.alu_ctrl = ALU_SLL;
               3'b010:  ctrl.alu_ctrl = ALU_SLT;
               3'b011:  ctrl.alu_ctrl = ALU_SLTU;
               3'b100:  ctrl.alu_ctrl = ALU_XOR;
               3'b101:  ctrl.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  ctrl.alu_ctrl = ALU_OR;
               default: ctrl.alu_ctrl = ALU_AND;
            endcase
         end
      endcase

      // an illegal slot stays an all-zero bubble apart from its flag
      ctrl.funct3 = ctrl.illegal ? 3'b000 : funct3;
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers and
// EX-stage branch resolution. PIPELINED=0 bypasses all stage registers.
module pipelined_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int PIPELINED  = 1,
   parameter int ALU_CTRL_W = 4
) (
   input logic                     clk,
   input logic                     rst,
   pipelined_control_unit_if.slave bus
);

   ex_ctrl_t   dec_c;
   ex_ctrl_t   dec_slot;
   ex_ctrl_t   ex_c;
   mem_ctrl_t  mem_c;
   wb_ctrl_t   wb_c;
   logic [2:0] imm_src;
   logic       br_cond;

   rv_ctrl_decode u_dec (
      .op      (bus.Op),
      .funct3  (bus.funct3),
      .funct7  (bus.funct7),
      .imm_src (imm_src),
      .ctrl    (dec_c)
   );

   // a flushed slot enters EX as a bubble
   assign dec_slot = bus.FlushE ? '0 : dec_c;

   if (PIPELINED != 0) begin : g_pipe
      ex_ctrl_t  id_ex_q;
      mem_ctrl_t ex_mem_q;
      wb_ctrl_t  mem_wb_q;

      // stage registers; reset clears all three on the same edge
      always_ff @(posedge clk) begin
         if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
         end else begin
            id_ex_q  <= dec_slot;
            ex_mem_q <= ex_to_mem(id_ex_q);
            mem_wb_q <= mem_to_wb(ex_mem_q);
         end
      end

      assign ex_c  = id_ex_q;
      assign mem_c = ex_mem_q;
      assign wb_c  = mem_wb_q;
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign ex_c  = dec_slot;
      assign mem_c = ex_to_mem(ex_c);
      assign wb_c  = mem_to_wb(mem_c);
   end

   // branch condition selected by the EX instruction's funct3
   always_comb begin
      br_cond = 1'b0;
      case (ex_c.funct3)
         3'b000:  br_cond = bus.ZeroE;
         3'b001:  br_cond = ~bus.ZeroE;
         3'b100:  br_cond = bus.LtE;
         3'b101:  br_cond = ~bus.LtE;
         3'b110:  br_cond = bus.LtuE;
         3'b111:  br_cond = ~bus.LtuE;
         default: br_cond = 1'b0;
      endcase
   end

   assign bus.ImmSrcD     = imm_src;
   assign bus.IllegalD    = dec_c.illegal;
   assign bus.ALUControlE = ALU_CTRL_W'(ex_c.alu_ctrl);
   assign bus.ALUSrcE     = ex_c.alu_src;
   assign bus.JalrE       = ex_c.jalr;
   assign bus.PCSrcE      = ex_c.jump | (ex_c.branch & br_cond);
   assign bus.IllegalE    = ex_c.illegal;
   assign bus.MemWriteM   = mem_c.mem_write;
   assign bus.RegWriteM   = mem_c.reg_write;
   assign bus.ResultSrcM  = mem_c.result_src;
   assign bus.RegWriteW   = wb_c.reg_write;
   assign bus.ResultSrcW  = wb_c.result_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and random stimulus against a stage-history reference model. A second,
// unpipelined instance is compared with plain decode every cycle.
module tb_pipelined_control_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_control_unit_if #(.ALU_CTRL_W(4)) b1 ();
   pipelined_control_unit_if #(.ALU_CTRL_W(4)) b0 ();

   pipelined_control_unit #(.PIPELINED(1), .ALU_CTRL_W(4)) u_dut (
      .clk (clk), .rst (rst), .bus (b1)
   );
   pipelined_control_unit #(.PIPELINED(0), .ALU_CTRL_W(4)) u_flat (
      .clk (clk), .rst (rst), .bus (b0)
   );

   int checks = 0;
   int errors = 0;

   // reference record for one instruction
   typedef struct packed {
      logic       rw, as, mw;
      logic [1:0] rs;
      logic       br, jp, jr;
      logic [3:0] ac;
      logic       il;
      logic [2:0] f3;
      logic [2:0] imm;
   } mrec_t;

   mrec_t me, mm, mw;
   bit    mvalid = 0;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IA = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, BAD = 7'b1111111;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ALU op named by funct3, with the SUB/SRA alternates
   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt, input logic is_r);
      case (f3)
         3'd0: return (is_r && alt) ? 4'd1 : 4'd0;
         3'd1: return 4'd7;
         3'd2: return 4'd5;
         3'd3: return 4'd6;
         3'd4: return 4'd4;
         3'd5: return alt ? 4'd9 : 4'd8;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic mrec_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      mrec_t r = '0;
      case (op)
         LW:   begin r.rw = 1; r.as = 1; r.rs = 2'b01; end
         SW:   begin r.as = 1; r.mw = 1; r.imm = 3'b001; end
         RT:   begin r.rw = 1; r.ac = alu_ref(f3, f7[5], 1'b1); end
         IA:   begin r.rw = 1; r.as = 1; r.ac = alu_ref(f3, f7[5], 1'b0); end
         BR:   begin r.br = 1; r.ac = 4'd1; r.imm = 3'b010; end
         JAL:  begin r.rw = 1; r.rs = 2'b10; r.jp = 1; r.imm = 3'b011; end
         JALR: begin r.rw = 1; r.as = 1; r.rs = 2'b10; r.jp = 1; r.jr = 1; end
         LUI:  begin r.rw = 1; r.as = 1; r.rs = 2'b11; r.imm = 3'b100; end
         default: r.il = 1;
      endcase
      if (!r.il) r.f3 = f3;
      return r;
   endfunction

   function automatic logic bcond(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
      case (f3)
         3'b000: return z;
         3'b001: return !z;
         3'b100: return lt;
         3'b101: return !lt;
         3'b110: return ltu;
         3'b111: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic fl, input logic z, input logic lt, input logic ltu);
      b1.Op = op; b1.funct3 = f3; b1.funct7 = f7; b1.FlushE = fl;
      b1.ZeroE = z; b1.LtE = lt; b1.LtuE = ltu;
      b0.Op = op; b0.funct3 = f3; b0.funct7 = f7; b0.FlushE = fl;
      b0.ZeroE = z; b0.LtE = lt; b0.LtuE = ltu;
   endtask

   // one clock: drive, check combinational outputs, clock, check stage outputs
   task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic fl, input logic z, input logic lt, input logic ltu, input logic r);
      mrec_t d, dz;
      drive(op, f3, f7, fl, z, lt, ltu);
      rst = r;
      #1;
      d  = ref_dec(op, f3, f7);
      dz = fl ? '0 : d;
      if (op != RT) chk("ImmSrcD", b1.ImmSrcD, d.imm);
      chk("IllegalD", b1.IllegalD, d.il);
      if (mvalid) chk("PCSrcE", b1.PCSrcE, me.jp | (me.br & bcond(me.f3, z, lt, ltu)));
      chk("flat_ALUControlE", b0.ALUControlE, dz.ac);
      chk("flat_ALUSrcE", b0.ALUSrcE, dz.as);
      chk("flat_JalrE", b0.JalrE, dz.jr);
      chk("flat_IllegalE", b0.IllegalE, dz.il);
      chk("flat_PCSrcE", b0.PCSrcE, dz.jp | (dz.br & bcond(dz.f3, z, lt, ltu)));
      chk("flat_MemWriteM", b0.MemWriteM, dz.mw);
      chk("flat_RegWriteM", b0.RegWriteM, dz.rw);
      chk("flat_ResultSrcM", b0.ResultSrcM, dz.rs);
      chk("flat_RegWriteW", b0.RegWriteW, dz.rw);
      chk("flat_ResultSrcW", b0.ResultSrcW, dz.rs);
      @(posedge clk);
      if (r) begin
         me = '0; mm = '0; mw = '0; mvalid = 1;
      end else begin
         mw = mm; mm = me; me = dz;
      end
      #1;
      if (mvalid) begin
         chk("ALUControlE", b1.ALUControlE, me.ac);
         chk("ALUSrcE", b1.ALUSrcE, me.as);
         chk("JalrE", b1.JalrE, me.jr);
         chk("IllegalE", b1.IllegalE, me.il);
         chk("MemWriteM", b1.MemWriteM, mm.mw);
         chk("RegWriteM", b1.RegWriteM, mm.rw);
         chk("ResultSrcM", b1.ResultSrcM, mm.rs);
         chk("RegWriteW", b1.RegWriteW, mw.rw);
         chk("ResultSrcW", b1.ResultSrcW, mw.rs);
      end
   endtask

   task automatic nop(input logic z, input logic lt, input logic ltu);
      cyc(IA, 3'b000, 7'd0, 1'b0, z, lt, ltu, 1'b0);
   endtask

   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
      logic [2:0] imm; logic ill; logic [3:0] ac;
      logic as, jr, rw, mw; logic [1:0] rs;
   } vec_t;

   typedef struct {
      logic [2:0] f3; logic z, lt, ltu; logic exp;
   } bvec_t;

   initial begin
      vec_t  tv[$];
      bvec_t bv[$];
      logic [6:0] ops [8];
      logic [2:0] bf3 [4];
      int n;

      //            op    f3      f7          imm    ill  ac     as jr rw mw rs
      tv.push_back('{RT,  3'd0, 7'b0100000, 3'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{RT,  3'd0, 7'b0000000, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{RT,  3'd5, 7'b0100000, 3'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{RT,  3'd3, 7'b0000000, 3'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{RT,  3'd1, 7'b0000000, 3'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd4, 7'b0000000, 3'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd0, 7'b0100000, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd5, 7'b0100000, 3'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd5, 7'b0000000, 3'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd2, 7'b0000000, 3'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd6, 7'b0000000, 3'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{IA,  3'd7, 7'b0000000, 3'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
      tv.push_back('{LW,  3'd2, 7'b0000000, 3'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01});
      tv.push_back('{SW,  3'd2, 7'b0000000, 3'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00});
      tv.push_back('{LUI, 3'd0, 7'b0000000, 3'd4, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11});
      tv.push_back('{BR,  3'd0, 7'b0000000, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tv.push_back('{BAD, 3'd0, 7'b0000000, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
      tv.push_back('{JAL, 3'd0, 7'b0000000, 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10});
      tv.push_back('{JALR,3'd0, 7'b0000000, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10});

      //            f3    z     lt    ltu   PCSrcE
      bv.push_back('{3'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      bv.push_back('{3'd0, 1'b0, 1'b1, 1'b1, 1'b0});
      bv.push_back('{3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
      bv.push_back('{3'd1, 1'b0, 1'b0, 1'b0, 1'b1});
      bv.push_back('{3'd4, 1'b0, 1'b1, 1'b0, 1'b1});
      bv.push_back('{3'd4, 1'b1, 1'b0, 1'b1, 1'b0});
      bv.push_back('{3'd5, 1'b0, 1'b0, 1'b1, 1'b1});
      bv.push_back('{3'd6, 1'b0, 1'b0, 1'b1, 1'b1});
      bv.push_back('{3'd7, 1'b0, 1'b0, 1'b1, 1'b0});
      bv.push_back('{3'd7, 1'b1, 1'b1, 1'b0, 1'b1});
      bv.push_back('{3'd2, 1'b1, 1'b1, 1'b1, 1'b0});
      bv.push_back('{3'd3, 1'b1, 1'b1, 1'b1, 1'b0});

      // reset: two cycles high, then everything registered reads zero
      cyc(IA, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(JAL, 3'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_ALUControlE", b1.ALUControlE, 0);
      chk("rst_ALUSrcE", b1.ALUSrcE, 0);
      chk("rst_JalrE", b1.JalrE, 0);
      chk("rst_IllegalE", b1.IllegalE, 0);
      chk("rst_MemWriteM", b1.MemWriteM, 0);
      chk("rst_RegWriteM", b1.RegWriteM, 0);
      chk("rst_ResultSrcM", b1.ResultSrcM, 0);
      chk("rst_RegWriteW", b1.RegWriteW, 0);
      chk("rst_ResultSrcW", b1.ResultSrcW, 0);
      rst = 1'b0;
      #1;
      chk("rst_PCSrcE", b1.PCSrcE, 0);

      // decode table, streamed back to back; M/W checked against earlier rows
      for (int i = 0; i < tv.size(); i++) begin
         cyc(tv[i].op, tv[i].f3, tv[i].f7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (tv[i].op != RT) chk("tv_ImmSrcD", b1.ImmSrcD, tv[i].imm);
         chk("tv_IllegalD", b1.IllegalD, tv[i].ill);
         chk("tv_ALUControlE", b1.ALUControlE, tv[i].ac);
         chk("tv_ALUSrcE", b1.ALUSrcE, tv[i].as);
         chk("tv_JalrE", b1.JalrE, tv[i].jr);
         chk("tv_IllegalE", b1.IllegalE, tv[i].ill);
         if (i >= 1) begin
            chk("tv_MemWriteM", b1.MemWriteM, tv[i-1].mw);
            chk("tv_RegWriteM", b1.RegWriteM, tv[i-1].rw);
            chk("tv_ResultSrcM", b1.ResultSrcM, tv[i-1].rs);
         end
         if (i >= 2) begin
            chk("tv_RegWriteW", b1.RegWriteW, tv[i-2].rw);
            chk("tv_ResultSrcW", b1.ResultSrcW, tv[i-2].rs);
         end
      end
      n = tv.size();
      nop(1'b0, 1'b0, 1'b0);
      chk("tv_tail_RegWriteM", b1.RegWriteM, tv[n-1].rw);
      chk("tv_tail_RegWriteW", b1.RegWriteW, tv[n-2].rw);
      nop(1'b0, 1'b0, 1'b0);
      chk("tv_tail_ResultSrcW", b1.ResultSrcW, tv[n-1].rs);

      // branch condition table: flags sampled while the branch sits in EX
      for (int i = 0; i < bv.size(); i++) begin
         cyc(BR, bv[i].f3, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         drive(IA, 3'd0, 7'd0, 1'b0, bv[i].z, bv[i].lt, bv[i].ltu);
         #1;
         chk("br_PCSrcE", b1.PCSrcE, bv[i].exp);
         nop(bv[i].z, bv[i].lt, bv[i].ltu);
      end

      // beq/bne/blt/bgeu against every flag combination
      bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4; bf3[3] = 3'd7;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 8; k++) begin
            cyc(BR, bf3[i], 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            nop(k[0], k[1], k[2]);
         end
      end

      // jal in EX redirects; a flushed jal does not, and the older lw still retires
      cyc(JAL, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jal_PCSrcE", b1.PCSrcE, 1);
      cyc(LW, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(JAL, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_PCSrcE", b1.PCSrcE, 0);
      chk("flush_ALUSrcE", b1.ALUSrcE, 0);
      chk("flush_RegWriteM", b1.RegWriteM, 1);
      chk("flush_ResultSrcM", b1.ResultSrcM, 2'b01);
      nop(1'b1, 1'b1, 1'b1);
      chk("flush_RegWriteW", b1.RegWriteW, 1);
      chk("flush_ResultSrcW", b1.ResultSrcW, 2'b01);
      chk("flush_bubble_RegWriteM", b1.RegWriteM, 0);

      // reset mid-stream with FlushE also high clears every stage at once
      cyc(LW, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(SW, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(JALR, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mid_rst_JalrE", b1.JalrE, 0);
      chk("mid_rst_MemWriteM", b1.MemWriteM, 0);
      chk("mid_rst_RegWriteW", b1.RegWriteW, 0);
      chk("mid_rst_ResultSrcW", b1.ResultSrcW, 0);

      // random stream
      ops = '{LW, SW, RT, IA, BR, JAL, JALR, LUI};
      for (int i = 0; i < 600; i++) begin
         logic [6:0] op;
         op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 7'($urandom);
         cyc(op, 3'($urandom), 7'($urandom), ($urandom_range(0, 7) == 0),
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
